// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache controller
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   cpu_read, cpu_write          load/store request (store wins when both are high)
//   cpu_addr, cpu_wdata          word address and store data
//   cpu_rdata, cpu_stall         load data and request-not-complete
//   mem_write                    line writeback strobe
//   mem_read_address             word address of the line being filled
//   mem_write_address/_data      word address and contents of the line being written back
//   mem_read_data                fill line, valid one cycle after mem_read_address
module dcache_controller #(
    parameter int INDEX_BITS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_read,
    input  logic         cpu_write,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_stall,
    output logic         mem_write,
    output logic [31:0]  mem_read_address,
    output logic [31:0]  mem_write_address,
    output logic [127:0] mem_write_data,
    input  logic [127:0] mem_read_data
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;
    localparam logic [1:0] COMPARE   = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] FILL_REQ  = 2'd2;
    localparam logic [1:0] FILL_RESP = 2'd3;

    logic [1:0]            state;
    logic [LINES-1:0]      valid;
    logic [LINES-1:0]      dirty;
    logic [TAG_W-1:0]      tags  [LINES];
    logic [127:0]          lines [LINES];
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic [6:0]            bit_off;
    logic                  req;
    logic                  hit;

    assign idx     = cpu_addr[INDEX_BITS+1:2];
    assign tag     = cpu_addr[31:INDEX_BITS+2];
    assign bit_off = {cpu_addr[1:0], 5'b0};
    assign req     = cpu_read | cpu_write;
    assign hit     = valid[idx] && (tags[idx] == tag);

    always_comb begin
        // Stall drops the instant reset asserts, even if a request is still held.
        cpu_stall         = rst_n && ((state != COMPARE) || (req && !hit));
        cpu_rdata         = (state == COMPARE && cpu_read && !cpu_write && hit) ? lines[idx][bit_off +: 32] : 32'h0;
        mem_write         = (state == WRITEBACK);
        mem_write_address = mem_write ? {tags[idx], idx, 2'b00} : 32'h0;
        mem_write_data    = mem_write ? lines[idx] : 128'h0;
        mem_read_address  = (state == FILL_REQ || state == FILL_RESP) ? {cpu_addr[31:2], 2'b00} : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COMPARE;
            valid <= '0;
            dirty <= '0;
        end else if (state == COMPARE) begin
            if (req && hit && cpu_write)
                dirty[idx] <= 1'b1;
            else if (req && !hit)
                state <= (valid[idx] && dirty[idx]) ? WRITEBACK : FILL_REQ;
        end else if (state == WRITEBACK) begin
            state <= FILL_REQ;
        end else if (state == FILL_REQ) begin
            state <= FILL_RESP;
        end else begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            state      <= COMPARE;
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (state == COMPARE && cpu_write && hit) begin
            lines[idx][bit_off +: 32] <= cpu_wdata;
        end else if (state == FILL_RESP) begin
            lines[idx] <= mem_read_data;
            tags[idx]  <= tag;
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: scoreboard bench for dcache_controller with a line-wide memory model
module tb_dcache_controller;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_read = 1'b0;
    logic         cpu_write = 1'b0;
    logic [31:0]  cpu_addr = 32'h0;
    logic [31:0]  cpu_wdata = 32'h0;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         mem_write;
    logic [31:0]  mem_read_address;
    logic [31:0]  mem_write_address;
    logic [127:0] mem_write_data;
    logic [127:0] mem_read_data = 128'h0;

    logic [31:0]  mem     [512];
    logic [31:0]  ref_mem [512];
    logic [31:0]  rdata_q [$];
    int           stall_q [$];
    logic [31:0]  wb_addr_q [$];
    logic [127:0] wb_data_q [$];
    int           passed = 0;
    int           total = 0;

    dcache_controller #(.INDEX_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_write(mem_write), .mem_read_address(mem_read_address),
        .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else passed++;
    endtask

    always @(posedge clk) begin
        if (mem_write)
            for (int k = 0; k < 4; k++) mem[mem_write_address[8:0] + 9'(k)] <= mem_write_data[32*k +: 32];
        mem_read_data <= {mem[mem_read_address[8:0] + 9'd3], mem[mem_read_address[8:0] + 9'd2],
                          mem[mem_read_address[8:0] + 9'd1], mem[mem_read_address[8:0]]};
    end

    always @(negedge clk) begin
        if (mem_write) begin
            if (wb_addr_q.size() == 0) begin
                check("wb_unexpected", mem_write_address, 32'hffff_ffff);
            end else begin
                check("wb_addr", mem_write_address, wb_addr_q.pop_front());
                check("wb_data", mem_write_data, wb_data_q.pop_front());
            end
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_stalls, input logic [31:0] victim);
        int n;
        logic [31:0] ra_seen;
        logic [8:0] a;
        logic [8:0] v;
        a = addr[8:0];
        v = victim[8:0];
        if (exp_stalls == 4) begin
            wb_addr_q.push_back(victim);
            wb_data_q.push_back({ref_mem[v + 9'd3], ref_mem[v + 9'd2], ref_mem[v + 9'd1], ref_mem[v]});
        end
        if (rd && !wr) rdata_q.push_back(ref_mem[a]);
        if (wr) ref_mem[a] = wd;
        stall_q.push_back(exp_stalls);
        cpu_read = rd;
        cpu_write = wr;
        cpu_addr = addr;
        cpu_wdata = wd;
        n = 0;
        ra_seen = 32'h0;
        @(negedge clk);
        while (cpu_stall && n < 20) begin
            n++;
            if (mem_read_address != 0) ra_seen = mem_read_address;
            @(negedge clk);
        end
        check("stalls", n, stall_q.pop_front());
        if (exp_stalls > 0) check("fill_addr", ra_seen, {addr[31:2], 2'b00});
        if (rd && !wr) check("rdata", cpu_rdata, rdata_q.pop_front());
        check("idle_mem", {mem_write, mem_read_address}, 33'h0);
        @(posedge clk);
        #1;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i] = 32'hA000_0000 + i;
            ref_mem[i] = 32'hA000_0000 + i;
        end
        repeat (3) @(negedge clk);
        check("rst_outs", {cpu_stall, cpu_rdata, mem_write, mem_read_address, mem_write_address, mem_write_data}, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // cold miss, then hit in the same line
        access(1, 0, 32'h40, 0, 3, 0);
        access(1, 0, 32'h42, 0, 0, 0);
        // store hit, read back
        access(0, 1, 32'h41, 32'h1234, 0, 0);
        access(1, 0, 32'h41, 0, 0, 0);
        @(negedge clk);
        check("idle", {cpu_stall, cpu_rdata}, 33'h0);
        @(posedge clk);
        #1;
        // dirty eviction of 0x40 by 0x80
        access(1, 0, 32'h80, 0, 4, 32'h40);
        // store miss, clean victim
        access(0, 1, 32'hC3, 32'hBEEF, 3, 0);
        // evicting 0xC0 writes the updated line back
        access(1, 0, 32'h40, 0, 4, 32'hC0);
        access(1, 0, 32'h41, 0, 0, 0);
        // read and write together behave as a store
        access(1, 1, 32'h42, 32'h5555, 0, 0);
        access(1, 0, 32'h42, 0, 0, 0);
        access(1, 0, 32'hC3, 0, 4, 32'h40);
        // dirty up the resident line, then reset mid-fill of another index
        access(0, 1, 32'hC1, 32'h7777, 0, 0);
        cpu_read = 1'b1;
        cpu_addr = 32'h104;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("fill_resp_ra", mem_read_address, 32'h104);
        rst_n = 1'b0;
        #1;
        check("rst_mid", {cpu_stall, mem_write, mem_read_address, cpu_rdata}, '0);
        cpu_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_mem[9'h0C1] = 32'hA000_00C1;
        @(posedge clk);
        #1;
        access(1, 0, 32'h104, 0, 3, 0);
        access(1, 0, 32'hC1, 0, 3, 0);
        check("wb_pending", wb_addr_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 4: line index width, giving 2^INDEX_BITS direct-mapped lines of 128 bits (4 x 32-bit words).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on posedge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port cpu_read, input, 1: load request.
REQ-005 SHALL have port cpu_write, input, 1: store request; takes priority if cpu_read is also high.
REQ-006 SHALL have port cpu_addr, input, 32: word address. Fields: [1:0] word offset, [INDEX_BITS+1:2] index, [31:INDEX_BITS+2] tag.
REQ-007 SHALL have port cpu_wdata, input, 32: store data.
REQ-008 SHALL have port cpu_rdata, output, 32: load data, valid when cpu_stall=0.
REQ-009 SHALL have port cpu_stall, output, 1: request not complete; CPU holds all request inputs stable while it is high.
REQ-010 SHALL have port mem_write, output, 1: line write to data memory.
REQ-011 SHALL have port mem_read_address, output, 32: word address of the line fill.
REQ-012 SHALL have port mem_write_address, output, 32: word address of the writeback line.
REQ-013 SHALL have port mem_write_data, output, 128: writeback line; word k at bits [32k+31:32k].
REQ-014 SHALL have port mem_read_data, input, 128: fill line, valid one cycle after mem_read_address is presented with mem_write=0.

Function
REQ-015 SHALL store, per line, a valid bit, a dirty bit, a tag and 128 data bits; the policy is write-back with write-allocate.
REQ-016 SHALL implement FSM states COMPARE, WRITEBACK, FILL_REQ and FILL_RESP.
REQ-017 SHALL register a hit in COMPARE when the indexed line is valid and its tag equals the request tag; cpu_stall=0 in that cycle (zero-wait hit).
REQ-018 On a read hit, SHALL drive cpu_rdata combinationally with the word selected by cpu_addr[1:0].
REQ-019 On a write hit, SHALL write cpu_wdata into the selected word at posedge and set the dirty bit; other words are unchanged.
REQ-020 On a miss in COMPARE with cpu_read or cpu_write high, SHALL assert cpu_stall combinationally in that cycle and move to WRITEBACK if the victim is valid and dirty, otherwise to FILL_REQ.
REQ-021 In WRITEBACK (1 cycle), SHALL drive mem_write=1, mem_write_address={victim tag, index, 2'b00} and mem_write_data=victim line, then go to FILL_REQ.
REQ-022 In FILL_REQ (1 cycle), SHALL drive mem_write=0 and mem_read_address={cpu_addr[31:2], 2'b00}, then go to FILL_RESP.
REQ-023 In FILL_RESP, SHALL hold mem_read_address, load mem_read_data into the line, set valid, clear dirty, write the tag, then return to COMPARE.
REQ-024 SHALL keep cpu_stall=1 in WRITEBACK, FILL_REQ and FILL_RESP; the retried request then hits in COMPARE.
REQ-025 Miss penalty SHALL be 3 stall cycles for a clean victim and 4 for a dirty victim.
REQ-026 Outside WRITEBACK, mem_write SHALL be 0 and mem_write_address and mem_write_data SHALL be 0.
REQ-027 Outside FILL_REQ and FILL_RESP, mem_read_address SHALL be 0.
REQ-028 With no request in COMPARE, SHALL hold cpu_stall=0, keep all state unchanged, and drive cpu_rdata=0.
REQ-029 Tag comparison SHALL use the full upper address bits; any address wrap-around is handled by the memory.

Reset
REQ-030 While rst_n=0, SHALL go to COMPARE and clear all valid and dirty bits, asynchronously.
REQ-031 During reset, outputs SHALL be cpu_stall=0, cpu_rdata=0, mem_write=0 and all mem_* addresses and data 0; tag and data arrays need not be cleared.
REQ-032 If reset is asserted mid-miss, SHALL abandon the operation and discard dirty data; after release, the first access misses.

Verification
REQ-033 Scenario 1: after reset, load addr 0x40 with memory words 0x40..0x43 = A,B,C,D -> stall for 3 cycles, mem_read_address=0x40, then cpu_rdata=A; an immediate load of 0x42 returns C with no stall.
REQ-034 Scenario 2: store 0x1234 to 0x41 (hit) -> no stall; a later load of 0x41 returns 0x1234 and mem_write stays 0.
REQ-035 Scenario 3: with INDEX_BITS=4, a dirty line at 0x40, then load 0x80 (same index, different tag) -> stall for 4 cycles; WRITEBACK drives mem_write_address=0x40 and mem_write_data={D,C,0x1234,A}; FILL drives mem_read_address=0x80.
REQ-036 Scenario 4: store-miss to 0xC3 -> line fill from 0xC0, then the word is written and the line is dirty; evicting it later writes back the updated line.
REQ-037 Scenario 5: cpu_read and cpu_write both high on a hit -> treated as a store.
REQ-038 Scenario 6: rst_n pulsed low during FILL_RESP -> mem_write=0 and cpu_stall=0 immediately; the next access to the same address misses.
